// File: rtl/sw_disp_pkg.sv
// ----------------------------------------------------------------------------
// sw_disp_pkg
//   Shared constants and helpers for the switch-counter display path.
//   Imported by the switch decoder stage and by the 7-segment driver stage.
//   Contents:
//     SW_WIDTH            number of slide switches
//     SW_CNT_W            width of a switch count (0..SW_WIDTH)
//     SW_DEBOUNCE_CYCLES  default debounce window (10 ms @ 100 MHz)
//     BCD_W               width of one BCD digit
//     bcd_t / bin_to_bcd  two-digit BCD split of a small binary count
// ----------------------------------------------------------------------------
package sw_disp_pkg;

    localparam int SW_WIDTH           = 16;
    localparam int SW_CNT_W           = $clog2(SW_WIDTH + 1);
    localparam int SW_DEBOUNCE_CYCLES = 1_000_000;
    localparam int BCD_W              = 4;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd_t;

    // Repeated compare/subtract; counts here never exceed 99, so nine
    // iterations always leave the remainder below ten.
    function automatic bcd_t bin_to_bcd(input logic [7:0] bin);
        logic [7:0] rem;
        bcd_t       res;
        rem      = bin;
        res.tens = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (rem >= 8'd10) begin
                rem      = rem - 8'd10;
                res.tens = res.tens + BCD_W'(1);
            end
        end
        res.ones = rem[BCD_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/sw_therm_decoder_if.sv
// ----------------------------------------------------------------------------
// sw_therm_decoder_if
//   Bundle between the raw switches, the switch decoder and its consumer.
//   Signals:
//     sw          raw switch word (asynchronous to clk)
//     sw_stable   debounced switch word
//     count       number of ones in sw_stable
//     bcd_tens    count / 10
//     bcd_ones    count % 10
//     code_valid  sw_stable is a thermometer code (incl. all-zero)
//     update      one-cycle pulse when the decoded outputs change
//   Modports:
//     slave   the decoder (consumes sw, produces everything else)
//     master  the environment (drives sw, observes the decoded outputs)
// ----------------------------------------------------------------------------
interface sw_therm_decoder_if
    import sw_disp_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] sw_stable;
    logic [CNT_W-1:0] count;
    logic [BCD_W-1:0] bcd_tens;
    logic [BCD_W-1:0] bcd_ones;
    logic             code_valid;
    logic             update;

    modport slave (
        input  sw,
        output sw_stable, count, bcd_tens, bcd_ones, code_valid, update
    );

    modport master (
        output sw,
        input  sw_stable, count, bcd_tens, bcd_ones, code_valid, update
    );

endinterface

// File: rtl/sw_therm_decoder_sync_debounce.sv
// ----------------------------------------------------------------------------
// sync_debounce
//   Two-flop synchroniser per switch bit followed by a whole-word debouncer
//   sharing one counter. A word is committed to sw_stable once it has been
//   seen unchanged for DEBOUNCE_CYCLES cycles and differs from sw_stable.
//   Ports:
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     sw         raw switch word
//     sw_stable  debounced switch word
//     commit     one-cycle pulse in the cycle sw_stable takes a new value
// ----------------------------------------------------------------------------
module sync_debounce
    import sw_disp_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             commit
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sw_sync;
    logic [WIDTH-1:0] candidate;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sw_sync   <= '0;
        end else begin
            sync_meta <= sw;
            sw_sync   <= sync_meta;
        end
    end

    // An input change always restarts the window, including in the terminal
    // cycle. The counter parks at TERMINAL, and the inequality guard keeps a
    // parked counter from re-committing the same word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate <= '0;
            cnt       <= '0;
            sw_stable <= '0;
            commit    <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (sw_sync != candidate) begin
                candidate <= sw_sync;
                cnt       <= '0;
            end else if (cnt == TERMINAL) begin
                if (candidate != sw_stable) begin
                    sw_stable <= candidate;
                    commit    <= 1'b1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sw_therm_decoder.sv
// ----------------------------------------------------------------------------
// sw_therm_decoder
//   Synchronises and debounces the slide switches, then presents the switch
//   count as binary and as two BCD digits, flags whether the word is a
//   thermometer code, and pulses update whenever these outputs change.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    sw_therm_decoder_if.slave: sw in; sw_stable, count, bcd_tens,
//            bcd_ones, code_valid, update out
// ----------------------------------------------------------------------------
module sw_therm_decoder
    import sw_disp_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    sw_therm_decoder_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sw_stable;
    logic             commit;

    logic [CNT_W-1:0] pop_c;
    logic [WIDTH:0]   ext_c;
    logic             valid_c;
    bcd_t             bcd_c;

    sync_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (bus.sw),
        .sw_stable (sw_stable),
        .commit    (commit)
    );

    assign bus.sw_stable = sw_stable;

    // Thermometer codes are 2^n-1, so adding one clears every set bit.
    // The extra top bit keeps the all-ones word from wrapping to zero.
    always_comb begin
        pop_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop_c = pop_c + CNT_W'(sw_stable[i]);
        end
        ext_c   = {1'b0, sw_stable};
        valid_c = (ext_c & (ext_c + (WIDTH+1)'(1))) == '0;
        bcd_c   = bin_to_bcd(8'(pop_c));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.count      <= '0;
            bus.bcd_tens   <= '0;
            bus.bcd_ones   <= '0;
            bus.code_valid <= 1'b1;
            bus.update     <= 1'b0;
        end else begin
            bus.update <= commit;
            if (commit) begin
                bus.count      <= pop_c;
                bus.bcd_tens   <= bcd_c.tens;
                bus.bcd_ones   <= bcd_c.ones;
                bus.code_valid <= valid_c;
            end
        end
    end

endmodule

// File: tb/tb_sw_therm_decoder.sv
module tb_sw_therm_decoder;
    import sw_disp_pkg::*;

    localparam int W   = 16;
    localparam int D   = 8;
    localparam int LAT = D + 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sw_therm_decoder_if #(.WIDTH(W)) bus ();

    sw_therm_decoder #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] sw;
        logic [4:0]  cnt;
        logic [3:0]  tens;
        logic [3:0]  ones;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [15:0] stable;
        logic [4:0]  cnt;
        logic [3:0]  tens;
        logic [3:0]  ones;
        logic        valid;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Independent reference: thermometer iff the word equals 2^popcount - 1.
    task automatic push_model(input logic [15:0] sw_v);
        exp_t        e;
        int unsigned n;
        logic [16:0] therm;
        n        = $countones(sw_v);
        therm    = (17'd1 << n) - 17'd1;
        e.stable = sw_v;
        e.cnt    = 5'(n);
        e.tens   = 4'(n / 10);
        e.ones   = 4'(n % 10);
        e.valid  = (therm[15:0] == sw_v);
        e.cyc    = cyc + LAT;
        sb_q.push_back(e);
    endtask

    task automatic push_vec(input vec_t v);
        exp_t e;
        e.stable = v.sw;
        e.cnt    = v.cnt;
        e.tens   = v.tens;
        e.ones   = v.ones;
        e.valid  = v.valid;
        e.cyc    = cyc + LAT;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d pending updates, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_sw_stable"}, bus.sw_stable, 0);
        check({name, "_count"},     bus.count, 0);
        check({name, "_tens"},      bus.bcd_tens, 0);
        check({name, "_ones"},      bus.bcd_ones, 0);
        check({name, "_valid"},     bus.code_valid, 1);
        check({name, "_update"},    bus.update, 0);
    endtask

    // Every update pulse must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (bus.update === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_update: got update with sw_stable=0x%0h, expected none",
                         bus.sw_stable);
            end else begin
                mon_e = sb_q.pop_front();
                check("upd_cycle",  cyc, mon_e.cyc);
                check("upd_stable", bus.sw_stable, mon_e.stable);
                check("upd_count",  bus.count, mon_e.cnt);
                check("upd_tens",   bus.bcd_tens, mon_e.tens);
                check("upd_ones",   bus.bcd_ones, mon_e.ones);
                check("upd_valid",  bus.code_valid, mon_e.valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h0005, 5'd2,  4'd0, 4'd2, 1'b0};
        vecs[1] = '{16'hFFFF, 5'd16, 4'd1, 4'd6, 1'b1};
        vecs[2] = '{16'h0000, 5'd0,  4'd0, 4'd0, 1'b1};
        vecs[3] = '{16'h00FF, 5'd8,  4'd0, 4'd8, 1'b1};
        vecs[4] = '{16'h8000, 5'd1,  4'd0, 4'd1, 1'b0};
        vecs[5] = '{16'h7FFF, 5'd15, 4'd1, 4'd5, 1'b1};
        vecs[6] = '{16'hFFFE, 5'd15, 4'd1, 4'd5, 1'b0};
        vecs[7] = '{16'h01FF, 5'd9,  4'd0, 4'd9, 1'b1};

        // 1. Reset with all switches up.
        rst_n  = 1'b0;
        bus.sw = 16'hFFFF;
        step(3);
        check_reset_vals("reset");
        bus.sw = 16'h0000;
        step(1);
        rst_n = 1'b1;
        step(20);

        // 2. Clean step.
        bus.sw = 16'h03FF;
        push_model(16'h03FF);
        wait_idle(40, "clean_step");
        step(5);

        // 3. Bounce on bit 0, period shorter than the window, then hold.
        for (int i = 0; i < 8; i++) begin
            bus.sw = (i % 2 == 0) ? 16'h0000 : 16'h0001;
            if (i == 7) push_model(16'h0001);
            step(5);
        end
        wait_idle(40, "bounce");
        step(5);

        // 4. Second change lands in the counter-terminal cycle of the first.
        bus.sw = 16'h0003;
        step(8);
        bus.sw = 16'h0007;
        push_model(16'h0007);
        wait_idle(40, "terminal");
        step(5);

        // 5. Table of words, including invalid codes and the extremes.
        for (int i = 0; i < 8; i++) begin
            bus.sw = vecs[i].sw;
            push_vec(vecs[i]);
            wait_idle(40, "table");
            step(2);
        end

        // 6. Reset four cycles into a debounce window.
        bus.sw = 16'h000F;
        step(7);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        step(3);
        rst_n = 1'b1;
        push_model(16'h000F);
        wait_idle(40, "post_reset");
        step(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
